// File: rtl/wall_pkg.sv
// wall_pkg: shared types and defaults for the wall spawn scheduler.
// Height width, fetch FSM states, default constants and the clamp helper.
package wall_pkg;

    localparam int HEIGHT_W           = 8;
    localparam int DEF_SPAWN_INTERVAL = 40;
    localparam int DEF_MIN_HEIGHT     = 8;
    localparam int DEF_MAX_HEIGHT     = 80;
    localparam int DEF_MIN_INTERVAL   = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    function automatic logic [HEIGHT_W-1:0] clamp_height(
        input logic [HEIGHT_W-1:0] h,
        input logic [HEIGHT_W-1:0] lo,
        input logic [HEIGHT_W-1:0] hi
    );
        if (h < lo) return lo;
        if (h > hi) return hi;
        return h;
    endfunction

endpackage

// File: rtl/wall_height_fifo.sv
// wall_height_fifo: DEPTH-entry synchronous FIFO of clamped wall heights.
// Registered level; simultaneous push and pop leave the level unchanged.
module wall_height_fifo
    import wall_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic [HEIGHT_W-1:0] din,
    input  logic                pop,
    output logic [HEIGHT_W-1:0] dout,
    output logic [LW-1:0]       level
);

    logic [HEIGHT_W-1:0] mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic                wr_en;
    logic                rd_en;

    assign wr_en = push && (level < LW'(DEPTH));
    assign rd_en = pop && (level != '0);
    assign dout  = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

    // storage array, data only so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wall_spawn_scheduler.sv
// wall_spawn_scheduler: prefetches clamped heights and spawns one wall per interval.
// Optional WALL_DIFFICULTY_RAMP_EN shortens the interval every 8 accepted walls.
module wall_spawn_scheduler
    import wall_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SPAWN_INTERVAL = DEF_SPAWN_INTERVAL,
    parameter int MIN_HEIGHT     = DEF_MIN_HEIGHT,
    parameter int MAX_HEIGHT     = DEF_MAX_HEIGHT,
    parameter int MIN_INTERVAL   = DEF_MIN_INTERVAL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                clear,
    input  logic                tick,
    output logic                gen_req,
    input  logic                gen_valid,
    input  logic [HEIGHT_W-1:0] gen_height,
    output logic                wall_valid,
    input  logic                wall_ready,
    output logic [HEIGHT_W-1:0] wall_height,
    output logic [7:0]          wall_id,
    output logic [2:0]          fifo_level
);

    localparam int MAXI = (SPAWN_INTERVAL > MIN_INTERVAL) ?
                          SPAWN_INTERVAL : MIN_INTERVAL;
    localparam int IW = $clog2(MAXI + 1);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [HEIGHT_W-1:0] MIN_H = HEIGHT_W'(MIN_HEIGHT);
    localparam logic [HEIGHT_W-1:0] MAX_H = HEIGHT_W'(MAX_HEIGHT);
    localparam logic [IW-1:0] START_IVAL  = IW'(SPAWN_INTERVAL);

    fetch_state_t        state;
    logic [IW-1:0]       timer;
    logic [IW-1:0]       ival;
    logic                pending;
    logic [LW-1:0]       level;
    logic [HEIGHT_W-1:0] head;
    logic [HEIGHT_W-1:0] push_h;
    logic                push;
    logic                pop;
    logic                accept;
    logic                due;

    assign push_h = clamp_height(gen_height, MIN_H, MAX_H);
    assign push   = (state == WAIT) && gen_valid && !clear;
    assign pop    = run && pending && (level != '0) && !wall_valid && !clear;
    assign accept = wall_valid && wall_ready;
    assign due    = run && tick && (timer == ival - IW'(1));

    assign fifo_level = 3'(level);

    wall_height_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .din   (push_h),
        .pop   (pop),
        .dout  (head),
        .level (level)
    );

    // fetch FSM: one outstanding generator request at a time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gen_req <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            gen_req <= 1'b0;
        end else begin
            gen_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (level < LW'(DEPTH)) begin
                        state   <= REQ;
                        gen_req <= 1'b1;
                    end
                end
                REQ:  state <= WAIT;
                WAIT: if (gen_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // spawn timer; a due while already pending is absorbed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer   <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            if (run && tick) timer <= due ? '0 : timer + IW'(1);
            if (due)      pending <= 1'b1;
            else if (pop) pending <= 1'b0;
        end
    end

`ifdef WALL_DIFFICULTY_RAMP_EN
    localparam logic [IW-1:0] MIN_I = IW'(MIN_INTERVAL);

    logic [IW-1:0] target;
    logic [2:0]    acc_cnt;

    // difficulty ramp: new target applied only at the next wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target  <= START_IVAL;
            ival    <= START_IVAL;
            acc_cnt <= '0;
        end else if (clear) begin
            target  <= START_IVAL;
            ival    <= START_IVAL;
            acc_cnt <= '0;
        end else begin
            if (due) ival <= target;
            if (accept) begin
                acc_cnt <= acc_cnt + 3'd1;
                if (acc_cnt == 3'd7) begin
                    target <= (target >= MIN_I + IW'(2)) ?
                              target - IW'(2) : MIN_I;
                end
            end
        end
    end
`else
    assign ival = START_IVAL;
`endif

    // wall descriptor register, held until the consumer takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wall_valid  <= 1'b0;
            wall_height <= '0;
            wall_id     <= '0;
        end else if (clear) begin
            wall_valid  <= 1'b0;
            wall_height <= '0;
            wall_id     <= '0;
        end else if (pop) begin
            wall_valid  <= 1'b1;
            wall_height <= head;
        end else if (accept) begin
            wall_valid  <= 1'b0;
            wall_id     <= wall_id + 8'd1;
        end
    end

endmodule

// File: tb/tb_wall_spawn_scheduler.sv
// tb_wall_spawn_scheduler: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_wall_spawn_scheduler;
    import wall_pkg::*;

    localparam int DEPTH = 4;
    localparam int IVAL  = 40;
    localparam int MIN_H = 8;
    localparam int MAX_H = 80;
    localparam int MIN_I = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                run;
    logic                clear;
    logic                tick;
    logic                gen_req;
    logic                gen_valid;
    logic [HEIGHT_W-1:0] gen_height;
    logic                wall_valid;
    logic                wall_ready;
    logic [HEIGHT_W-1:0] wall_height;
    logic [7:0]          wall_id;
    logic [2:0]          fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wall_spawn_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .tick        (tick),
        .gen_req     (gen_req),
        .gen_valid   (gen_valid),
        .gen_height  (gen_height),
        .wall_valid  (wall_valid),
        .wall_ready  (wall_ready),
        .wall_height (wall_height),
        .wall_id     (wall_id),
        .fifo_level  (fifo_level)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: heights queue, tick counter, pending flag
    int m_q[$];
    int m_timer, m_ival, m_target, m_acc, m_wh, m_wid;
    bit m_pend, m_wv, m_req, m_wait;

    function automatic int clampv(input int h);
        if (h < MIN_H) return MIN_H;
        if (h > MAX_H) return MAX_H;
        return h;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_timer = 0; m_pend = 0;
        m_wv = 0; m_wh = 0; m_wid = 0;
        m_req = 0; m_wait = 0;
        m_ival = IVAL; m_target = IVAL; m_acc = 0;
    endtask

    task automatic model_step();
        bit acc, give, take, due;
        if (clear) begin
            model_reset();
        end else begin
            acc  = m_wv && wall_ready;
            give = run && m_pend && (m_q.size() > 0) && !m_wv;
            take = m_wait && gen_valid;
            due  = run && tick && (m_timer == m_ival - 1);
            if (m_req) begin
                m_req = 0; m_wait = 1;
            end else if (m_wait) begin
                if (gen_valid) m_wait = 0;
            end else if (m_q.size() < DEPTH) begin
                m_req = 1;
            end
            if (give) begin
                m_wh = m_q.pop_front();
                m_wv = 1;
            end else if (acc) begin
                m_wv = 0;
                m_wid = (m_wid + 1) % 256;
            end
            if (take) m_q.push_back(clampv(int'(gen_height)));
            if (run && tick) m_timer = due ? 0 : m_timer + 1;
`ifdef WALL_DIFFICULTY_RAMP_EN
            if (due) m_ival = m_target;
            if (acc) begin
                m_acc++;
                if (m_acc % 8 == 0)
                    m_target = (m_target - 2 < MIN_I) ? MIN_I : m_target - 2;
            end
`endif
            m_pend = due || (m_pend && !give);
        end
    endtask

    task automatic compare_all();
        check("gen_req", gen_req, m_req);
        check("wall_valid", wall_valid, m_wv);
        check("wall_height", wall_height, m_wh);
        check("wall_id", wall_id, m_wid);
        check("fifo_level", fifo_level, m_q.size());
    endtask

    // generator model state
    int cyc = 0;
    int resp_at = -1;
    int lat = 3;
    bit stall = 0;
    bit owed = 0;
    bit spur = 0;
    int preset[$];
    bit rise = 0;
    bit pv = 0;

    function automatic int next_height();
        if (preset.size() > 0) return preset.pop_front();
        return int'($urandom_range(0, 255));
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        rise = wall_valid && !pv;
        pv = wall_valid;
        if (gen_req) begin
            if (stall) begin
                owed = 1; resp_at = -1;
            end else begin
                resp_at = cyc + lat;
            end
        end
        gen_valid = 1'b0;
        if (cyc == resp_at) begin
            gen_valid = 1'b1;
            gen_height = 8'(next_height());
        end else if (spur && $urandom_range(0, 19) == 0) begin
            gen_valid = 1'b1;
            gen_height = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_gen_req"}, gen_req, 0);
        check({pfx, "_wall_valid"}, wall_valid, 0);
        check({pfx, "_wall_height"}, wall_height, 0);
        check({pfx, "_wall_id"}, wall_id, 0);
        check({pfx, "_fifo_level"}, fifo_level, 0);
    endtask

    task automatic mid_reset();
        #3 reset = 1'b1;
        #2;
        check_zero("midrst");
        model_reset();
        gen_valid = 1'b0; resp_at = -1; owed = 0; pv = 0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    int nreq, saw, nr, tot, n, bad, h0, gvc, first, fh;
    int rc[100];
    int rh[4];
    int ri[4];
    int exp_h[4] = '{8, 45, 80, 80};

    initial begin
        reset = 1'b1; run = 1'b0; clear = 1'b0; tick = 1'b0;
        wall_ready = 1'b0; gen_valid = 1'b0; gen_height = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        model_reset();
        reset = 1'b0;

        // frozen game: FIFO fills, clamps applied, no walls
        preset = '{3, 45, 200, 80};
        run = 0; tick = 1; wall_ready = 1;
        nreq = 0; saw = 0;
        repeat (40) begin
            step();
            if (gen_req) nreq++;
            if (wall_valid) saw = 1;
        end
        check("p2_req_pulses", nreq, 4);
        check("p2_level", fifo_level, 4);
        check("p2_no_wall", saw, 0);

        // running game: one wall per 40 ticks
        run = 1;
        nr = 0; tot = 0;
        foreach (rh[i]) begin rh[i] = 0; ri[i] = 0; end
        repeat (175) begin
            step();
            if (rise) begin
                tot++;
                if (nr < 4) begin
                    rc[nr] = cyc; rh[nr] = wall_height; ri[nr] = wall_id;
                    nr++;
                end
            end
        end
        check("p3_walls", tot, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("p3_height%0d", i), rh[i], exp_h[i]);
        for (int i = 0; i < 3; i++)
            check($sformatf("p3_id%0d", i), ri[i], i);
        check("p3_gap01", rc[1] - rc[0], 40);
        check("p3_gap12", rc[2] - rc[1], 40);
        check("p3_refill", fifo_level, 4);

        // stalled generator: spawn waits, duplicate due absorbed
        stall = 1;
        n = 0;
        while (!(m_pend && m_q.size() == 0) && n < 400) begin
            step(); n++;
        end
        check("p4_drain_in_time", n < 400, 1);
        nr = 0;
        repeat (60) begin step(); if (rise) nr++; end
        check("p4_stalled_no_wall", nr, 0);
        n = 0;
        while (m_timer != 5 && n < 60) begin step(); n++; end
        check("p4_sync_in_time", n < 60, 1);
        gen_valid = 1'b1; gen_height = 8'd50;
        stall = 0; owed = 0; gvc = cyc;
        nr = 0; first = -1; fh = 0;
        repeat (20) begin
            step();
            if (rise) begin
                nr++;
                if (first < 0) begin first = cyc; fh = wall_height; end
            end
        end
        check("p4_single_wall", nr, 1);
        check("p4_push_to_valid", first - gvc, 2);
        check("p4_height", fh, 50);

        // back-pressure hold, then clear with a stale answer behind it
        wall_ready = 0;
        n = 0;
        while (!wall_valid && n < 100) begin step(); n++; end
        check("p5_wall_in_time", n < 100, 1);
        h0 = wall_height; bad = 0;
        repeat (100) begin
            step();
            if (!wall_valid || wall_height != h0) bad++;
        end
        check("p5_hold_stable", bad, 0);
        wall_ready = 1;
        n = 0;
        while (resp_at != cyc + 1 && n < 100) begin step(); n++; end
        check("p5_wait_in_time", n < 100, 1);
        clear = 1; step(); clear = 0;
        step();
        check("p5_level_cleared", fifo_level, 0);
        check("p5_id_cleared", wall_id, 0);
        check("p5_valid_cleared", wall_valid, 0);

        // random traffic with one asynchronous reset
        spur = 1;
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            tick = ($urandom_range(0, 3) != 0);
            wall_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 249) == 0);
            lat = int'($urandom_range(1, 5));
            step();
            if (i == 1500) mid_reset();
        end
        clear = 0; spur = 0; lat = 3;

`ifdef WALL_DIFFICULTY_RAMP_EN
        // difficulty ramp: 40 -> 38 after 8 walls, floor at 16
        run = 1; tick = 1; wall_ready = 1;
        clear = 1; step(); clear = 0;
        nr = 0; n = 0;
        while (nr < 100 && n < 6000) begin
            step(); n++;
            if (rise) begin rc[nr] = cyc; nr++; end
        end
        check("ramp_in_time", nr, 100);
        check("ramp_gap_pre", rc[8] - rc[7], 40);
        check("ramp_gap_38", rc[9] - rc[8], 38);
        check("ramp_gap_18", rc[96] - rc[95], 18);
        check("ramp_gap_16", rc[97] - rc[96], 16);
        check("ramp_gap_sat", rc[99] - rc[98], 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
